tpu_ctrl: RTL and testbench

TPU_CTRL -- requirements
Module: tpu_ctrl

---
 rtl/tpu_ctrl.sv | 172 +++++++++++++++++
 tb/tb_tpu_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_ctrl.sv
// tpu_ctrl: byte-stream host controller for a 2x2 matrix unit.
// Define TPU_CTRL_STATUS_EN to append a status byte after every RUN.
module tpu_ctrl #(
   parameter int TIMEOUT = 200
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        out_valid,
   output logic [7:0]  out_data,
   input  logic        out_ready,
   output logic        wt_wr_en,
   output logic        in_wr_en,
   output logic [1:0]  wr_addr,
   output logic [7:0]  wr_data,
   output logic        mxu_start,
   input  logic        mxu_done,
   output logic [1:0]  res_addr,
   input  logic [15:0] res_data,
   output logic        busy,
   output logic        err
);

`ifdef TPU_CTRL_STATUS_EN
   typedef enum logic [2:0] {
      IDLE, LOAD_W, LOAD_X, START, WAIT, DRAIN, STAT
   } state_t;
   localparam state_t POST = STAT;
`else
   typedef enum logic [2:0] {
      IDLE, LOAD_W, LOAD_X, START, WAIT, DRAIN
   } state_t;
   localparam state_t POST = IDLE;
`endif

   localparam logic [7:0] TO = 8'(TIMEOUT);

   state_t     state;
   logic [1:0] lcnt;
   logic [2:0] bcnt;
   logic [7:0] wcnt;
   logic       err_q;
   logic       wt_we_q;
   logic       in_we_q;
   logic [1:0] wr_addr_q;
   logic [7:0] wr_data_q;
   logic       start_q;

   logic       in_rdy;
   logic       out_vld;
   logic       in_acc;
   logic       out_acc;
   logic [1:0] hdr;
   logic [7:0] drain_byte;
   logic [7:0] out_byte;

   assign hdr = in_data[7:6];

   assign in_rdy = (state == IDLE) || (state == LOAD_W)
                || (state == LOAD_X);
`ifdef TPU_CTRL_STATUS_EN
   assign out_vld = (state == DRAIN) || (state == STAT);
`else
   assign out_vld = (state == DRAIN);
`endif

   assign in_acc  = in_valid && in_rdy;
   assign out_acc = out_ready && out_vld;

   // Result memory is read combinationally; odd bytes carry the high half.
   assign drain_byte = bcnt[0] ? res_data[15:8] : res_data[7:0];

`ifdef TPU_CTRL_STATUS_EN
   // err_q is only set on timeout, so it selects the status encoding.
   assign out_byte = (state == STAT)  ? (err_q ? 8'hFF : wcnt) :
                     (state == DRAIN) ? drain_byte : 8'h00;
`else
   assign out_byte = (state == DRAIN) ? drain_byte : 8'h00;
`endif

   // Everything is forced low while reset is held.
   assign in_ready  = rst_n && in_rdy;
   assign out_valid = rst_n && out_vld;
   assign out_data  = rst_n ? out_byte : 8'h00;
   assign busy      = rst_n && (state != IDLE);
   assign err       = rst_n && err_q;
   assign wt_wr_en  = rst_n && wt_we_q;
   assign in_wr_en  = rst_n && in_we_q;
   assign wr_addr   = rst_n ? wr_addr_q : 2'd0;
   assign wr_data   = rst_n ? wr_data_q : 8'h00;
   assign mxu_start = rst_n && start_q;
   assign res_addr  = rst_n ? bcnt[2:1] : 2'd0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         lcnt      <= 2'd0;
         bcnt      <= 3'd0;
         wcnt      <= 8'd0;
         err_q     <= 1'b0;
         wt_we_q   <= 1'b0;
         in_we_q   <= 1'b0;
         wr_addr_q <= 2'd0;
         wr_data_q <= 8'h00;
         start_q   <= 1'b0;
      end else begin
         wt_we_q <= 1'b0;
         in_we_q <= 1'b0;
         start_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (in_acc) begin
                  unique case (1'b1)
                     hdr == 2'b01: state <= LOAD_W;
                     hdr == 2'b10: state <= LOAD_X;
                     hdr == 2'b11: begin
                        state   <= START;
                        start_q <= 1'b1;
                        err_q   <= 1'b0;
                     end
                     default: ;
                  endcase
               end
            end
            LOAD_W, LOAD_X: begin
               if (in_acc) begin
                  wt_we_q   <= (state == LOAD_W);
                  in_we_q   <= (state == LOAD_X);
                  wr_addr_q <= lcnt;
                  wr_data_q <= in_data;
                  lcnt      <= lcnt + 2'd1;
                  if (lcnt == 2'd3)
                     state <= IDLE;
               end
            end
            START: begin
               wcnt  <= 8'd1;
               state <= WAIT;
            end
            WAIT: begin
               // Done has priority over a timeout on the same cycle.
               if (mxu_done) begin
                  bcnt  <= 3'd0;
                  state <= DRAIN;
               end else if (wcnt == TO) begin
                  err_q <= 1'b1;
                  state <= POST;
               end else begin
                  wcnt <= wcnt + 8'd1;
               end
            end
            DRAIN: begin
               if (out_acc) begin
                  bcnt <= bcnt + 3'd1;
                  if (bcnt == 3'd7)
                     state <= POST;
               end
            end
`ifdef TPU_CTRL_STATUS_EN
            STAT: begin
               if (out_acc)
                  state <= IDLE;
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tpu_ctrl.sv
// tb_tpu_ctrl: randomized bench for tpu_ctrl with a 2x2 MXU model
// and a transaction-level reference model of the host protocol.
`timescale 1ns/1ps
module tb_tpu_ctrl;

   localparam int TIMEOUT = 200;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_ready;
   logic        wt_wr_en;
   logic        in_wr_en;
   logic [1:0]  wr_addr;
   logic [7:0]  wr_data;
   logic        mxu_start;
   logic        mxu_done;
   logic [1:0]  res_addr;
   logic [15:0] res_data;
   logic        busy;
   logic        err;

   always #5 clk = ~clk;

   tpu_ctrl #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .wt_wr_en(wt_wr_en), .in_wr_en(in_wr_en),
      .wr_addr(wr_addr), .wr_data(wr_data),
      .mxu_start(mxu_start), .mxu_done(mxu_done),
      .res_addr(res_addr), .res_data(res_data),
      .busy(busy), .err(err)
   );

   int checks = 0;
   int errors = 0;

   logic [3:0][7:0]  model_w, model_x;
   logic             model_err;
   logic             use_mxu;
   logic [3:0][15:0] fixed_res;
   logic [3:0][15:0] res_mem = '0;
   logic [3:0][7:0]  cap_w = '0, cap_x = '0;
   logic [7:0]       got[$];

   function automatic logic [3:0][15:0] prod(input logic [3:0][7:0] w,
                                             input logic [3:0][7:0] x);
      logic [3:0][15:0] r;
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++)
            r[i*2+j] = 16'(w[i*2]) * 16'(x[j])
                     + 16'(w[i*2+1]) * 16'(x[2+j]);
      return r;
   endfunction

   // MXU model: latches what the controller writes, computes on start.
   always @(posedge clk) begin
      if (wt_wr_en) cap_w[wr_addr] <= wr_data;
      if (in_wr_en) cap_x[wr_addr] <= wr_data;
      if (mxu_start) res_mem <= use_mxu ? prod(cap_w, cap_x) : fixed_res;
   end
   assign res_data = res_mem[res_addr];

   task automatic check(input string tag, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      if (gap > 0) begin
         in_valid = 1'b0;
         repeat (gap) step();
      end
      in_valid = 1'b1;
      in_data  = b;
      n = 0;
      while (!in_ready && n < 50) begin
         step();
         n++;
      end
      check("send_ready", 32'(in_ready), 1);
      step();
   endtask

   task automatic load(input bit is_x, input logic [3:0][7:0] d,
                       input int gap);
      logic [1:0] we_exp;
      we_exp = is_x ? 2'b01 : 2'b10;
      send_byte((is_x ? 8'h80 : 8'h40) | 8'($urandom % 64), gap);
      check("hdr_we", 32'({wt_wr_en, in_wr_en}), 0);
      check("hdr_busy", 32'(busy), 1);
      for (int k = 0; k < 4; k++) begin
         send_byte(d[k], gap);
         check("wr_en", 32'({wt_wr_en, in_wr_en}), 32'(we_exp));
         check("wr_addr", 32'(wr_addr), k);
         check("wr_data", 32'(wr_data), 32'(d[k]));
      end
      in_valid = 1'b0;
      check("load_idle", 32'({busy, in_ready}), 32'b01);
      if (is_x) model_x = d;
      else      model_w = d;
      step();
      check("wr_en_off", 32'({wt_wr_en, in_wr_en}), 0);
   endtask

   task automatic collect(input int n, input int stall, input int take);
      int   cnt = 0;
      int   cyc = 0;
      logic pend = 1'b0;
      logic [7:0] held = 8'h00;
      got.delete();
      check("first_valid", 32'(out_valid), (n > 0) ? 1 : 0);
      while (cnt < n && cnt < take && cyc < 400) begin
         if (pend) begin
            check("hold_valid", 32'(out_valid), 1);
            check("hold_data", 32'(out_data), 32'(held));
         end
         out_ready = (cyc < stall) ? 1'b0 : ($urandom % 4 != 0);
         if (out_valid && out_ready) begin
            got.push_back(out_data);
            cnt++;
            pend = 1'b0;
         end else begin
            pend = out_valid;
            held = out_data;
         end
         step();
         cyc++;
      end
      out_ready = 1'b0;
      check("byte_count", cnt, (take < n) ? take : n);
   endtask

   // delay = cycles from mxu_start to mxu_done; 0 or > TIMEOUT never done.
   task automatic run(input int delay, input int stall, input int take);
      logic [7:0]       exp[$];
      logic [3:0][15:0] r;
      bit               ok;
      ok = (delay > 0) && (delay <= TIMEOUT);
      send_byte(8'hC0 | 8'($urandom % 64), $urandom % 2);
      in_valid  = 1'b0;
      model_err = 1'b0;
      check("run_start", 32'(mxu_start), 1);
      check("run_err_clr", 32'(err), 0);
      for (int i = 1; i <= TIMEOUT; i++) begin
         step();
         if (i == 1) check("start_pulse", 32'(mxu_start), 0);
         check("wait_flags", 32'({busy, in_ready, out_valid}), 32'b100);
         if (ok && i == delay) begin
            mxu_done = 1'b1;
            step();
            mxu_done = 1'b0;
            break;
         end
         if (!ok && i == TIMEOUT) step();
      end
      if (ok) begin
         r = use_mxu ? prod(model_w, model_x) : fixed_res;
         for (int i = 0; i < 4; i++) begin
            exp.push_back(r[i][7:0]);
            exp.push_back(r[i][15:8]);
         end
`ifdef TPU_CTRL_STATUS_EN
         exp.push_back(8'(delay));
`endif
      end else begin
         model_err = 1'b1;
`ifdef TPU_CTRL_STATUS_EN
         exp.push_back(8'hFF);
`endif
      end
      check("run_err", 32'(err), 32'(model_err));
      collect(exp.size(), stall, take);
      for (int i = 0; i < got.size() && i < exp.size(); i++)
         check($sformatf("out_byte%0d", i), 32'(got[i]), 32'(exp[i]));
      if (take >= exp.size())
         check("run_end", 32'({busy, out_valid}), 0);
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      mxu_done  = 1'b0;
      step();
      check("rst_flags", 32'({in_ready, out_valid, busy, err, mxu_start,
                              wt_wr_en, in_wr_en}), 0);
      check("rst_buses", {wr_addr, res_addr, wr_data, out_data}, 0);
      rst_n     = 1'b1;
      model_err = 1'b0;
      step();
      check("post_rst", 32'({busy, in_ready, err, out_valid}), 32'b0100);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b0;
      mxu_done  = 1'b0;
      use_mxu   = 1'b0;
      model_err = 1'b0;
      model_w   = '0;
      model_x   = '0;
      fixed_res = {16'hFFFF, 16'h0001, 16'hABCD, 16'h1234};
      repeat (2) step();
      do_reset();

      load(1'b0, {8'h44, 8'h33, 8'h22, 8'h11}, 0);
      run(5, 0, 99);
      run(3, 10, 99);
      run(0, 0, 99);
      check("err_sticky", 32'(err), 1);
      run(2, 0, 99);
      run(TIMEOUT, 0, 99);
      run(TIMEOUT + 1, 0, 99);

      send_byte(8'h80, 0);
      send_byte(8'hA5, 0);
      send_byte(8'h5A, 0);
      in_valid = 1'b0;
      do_reset();
      load(1'b1, {8'h04, 8'h03, 8'h02, 8'h01}, 0);
      run(4, 0, 3);
      do_reset();
      run(0, 0, 99);
      do_reset();

      use_mxu = 1'b1;
      load(1'b0, 32'($urandom), 1);
      load(1'b1, 32'($urandom), 0);
      run(1, 1, 99);
      repeat (40) begin
         case ($urandom % 5)
            0: load(1'b0, 32'($urandom), $urandom % 2);
            1: load(1'b1, 32'($urandom), $urandom % 2);
            2: begin
               send_byte(8'($urandom % 64), $urandom % 2);
               in_valid = 1'b0;
               check("nop_idle", 32'({busy, mxu_start}), 0);
            end
            default: run(($urandom % 16 == 0) ? 0 : 1 + $urandom % 12,
                         $urandom % 3, 99);
         endcase
         check("err_model", 32'(err), 32'(model_err));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
